// File: rtl/maze_path_checker_if.sv
// Solver-side snoop bus plus the checker's verdict outputs.
// The bench drives through master; the checker sits on slave.
interface maze_path_checker_if;
    logic       in_valid;
    logic       maze;
    logic       out_valid;
    logic       maze_not_valid;
    logic [3:0] out_x;
    logic [3:0] out_y;
    logic       chk_done;
    logic       chk_pass;
    logic       chk_nopath;
    logic [2:0] chk_err;
    logic [7:0] chk_len;

    modport master (
        output in_valid, maze, out_valid, maze_not_valid, out_x, out_y,
        input  chk_done, chk_pass, chk_nopath, chk_err, chk_len
    );

    modport slave (
        input  in_valid, maze, out_valid, maze_not_valid, out_x, out_y,
        output chk_done, chk_pass, chk_nopath, chk_err, chk_len
    );
endinterface

// File: rtl/maze_path_checker.sv
// Snoops the serial maze load, then checks the solver's path burst (or no-path flag)
// and issues one registered verdict per maze.
module maze_path_checker #(
    parameter int DIM     = 15,
    parameter int START_X = 1,
    parameter int START_Y = 1,
    parameter int END_X   = 13,
    parameter int END_Y   = 13,
    parameter int MAX_LEN = 225,
    parameter int TIMEOUT = 1000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    maze_path_checker_if.slave  bus
);
    localparam int CELLS     = DIM * DIM;
    localparam int START_IDX = START_Y * DIM + START_X;
    localparam int END_IDX   = END_Y * DIM + END_X;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_START   = 3'd1;
    localparam logic [2:0] ERR_WALL    = 3'd2;
    localparam logic [2:0] ERR_STEP    = 3'd3;
    localparam logic [2:0] ERR_REVISIT = 3'd4;
    localparam logic [2:0] ERR_END     = 3'd5;
    localparam logic [2:0] ERR_LONG    = 3'd6;
    localparam logic [2:0] ERR_PROTO   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_PATH   = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CELLS-1:0] r_open;
    logic [CELLS-1:0] r_visited;
    logic [7:0]       r_cnt;
    logic [15:0]      r_timer;
    logic [7:0]       r_len;
    logic [2:0]       r_err;
    logic             r_nopath;
    logic [3:0]       r_prev_x;
    logic [3:0]       r_prev_y;
    logic             r_done;
    logic             r_pass;
    logic             r_out_nopath;
    logic [2:0]       r_out_err;
    logic [7:0]       r_out_len;

    logic [2:0]       w_err_nxt;
    logic             w_nopath_nxt;
    logic             w_take_pt;
    logic [2:0]       w_pt_err;
    logic             w_oob;
    logic [7:0]       w_idx;
    logic             w_open_bit;
    logic             w_visited_bit;
    logic             w_first;

    function automatic logic is_unit_step(input logic [3:0] ax, input logic [3:0] ay,
                                          input logic [3:0] bx, input logic [3:0] by);
        logic [3:0] dx;
        logic [3:0] dy;
        dx = (ax > bx) ? (ax - bx) : (bx - ax);
        dy = (ay > by) ? (ay - by) : (by - ay);
        return ({1'b0, dx} + {1'b0, dy}) == 5'd1;
    endfunction

    // Out-of-range coordinates must never index the bitmaps.
    assign w_oob         = (int'(bus.out_x) >= DIM) || (int'(bus.out_y) >= DIM);
    assign w_idx         = 8'(int'(bus.out_y) * DIM + int'(bus.out_x));
    assign w_open_bit    = w_oob ? 1'b0 : r_open[w_idx];
    assign w_visited_bit = w_oob ? 1'b0 : r_visited[w_idx];
    assign w_first       = (r_len == 8'd0);

    // Error for the current path point, highest priority first.
    always_comb begin
        w_pt_err = ERR_NONE;
        if (bus.maze_not_valid) begin
            w_pt_err = ERR_PROTO;
        end else if (w_first && !((bus.out_x == 4'(START_X)) && (bus.out_y == 4'(START_Y)))) begin
            w_pt_err = ERR_START;
        end else if (!w_open_bit) begin
            w_pt_err = ERR_WALL;
        end else if (!w_first && !is_unit_step(bus.out_x, bus.out_y, r_prev_x, r_prev_y)) begin
            w_pt_err = ERR_STEP;
        end else if (w_visited_bit) begin
            w_pt_err = ERR_REVISIT;
        end else if (r_len >= 8'(MAX_LEN)) begin
            w_pt_err = ERR_LONG;
        end else begin
            w_pt_err = ERR_NONE;
        end
    end

    // Next state and first-error latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_err_nxt    = r_err;
        w_nopath_nxt = r_nopath;
        w_take_pt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_err_nxt    = ERR_NONE;
                w_nopath_nxt = 1'b0;
                if (bus.in_valid) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!bus.in_valid) begin
                    w_state_nxt = ST_REPORT;
                    w_err_nxt   = ERR_PROTO;
                end else if (r_cnt == 8'(CELLS - 1)) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_WAIT: begin
                if (bus.out_valid) begin
                    w_state_nxt = ST_PATH;
                    w_take_pt   = 1'b1;
                    w_err_nxt   = w_pt_err;
                end else if (bus.maze_not_valid) begin
                    w_state_nxt  = ST_REPORT;
                    w_nopath_nxt = 1'b1;
                    w_err_nxt    = (r_open[START_IDX] && r_open[END_IDX]) ? ERR_LONG : ERR_NONE;
                end else if (r_timer == 16'(TIMEOUT)) begin
                    w_state_nxt = ST_REPORT;
                    w_err_nxt   = ERR_PROTO;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_PATH: begin
                if (bus.out_valid) begin
                    w_take_pt = 1'b1;
                    w_err_nxt = (r_err == ERR_NONE) ? w_pt_err : r_err;
                end else begin
                    w_state_nxt = ST_REPORT;
                    if ((r_err == ERR_NONE) &&
                        !((r_prev_x == 4'(END_X)) && (r_prev_y == 4'(END_Y)))) begin
                        w_err_nxt = ERR_END;
                    end else begin
                        w_err_nxt = r_err;
                    end
                end
            end
            ST_REPORT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, bitmaps, counters and registered verdict.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_open       <= '0;
            r_visited    <= '0;
            r_cnt        <= 8'd0;
            r_timer      <= 16'd0;
            r_len        <= 8'd0;
            r_err        <= ERR_NONE;
            r_nopath     <= 1'b0;
            r_prev_x     <= 4'd0;
            r_prev_y     <= 4'd0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_out_nopath <= 1'b0;
            r_out_err    <= ERR_NONE;
            r_out_len    <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_err    <= w_err_nxt;
            r_nopath <= w_nopath_nxt;
            if ((r_state == ST_IDLE) && bus.in_valid) begin
                r_open[0] <= bus.maze;
                r_cnt     <= 8'd1;
                r_visited <= '0;
                r_len     <= 8'd0;
                r_timer   <= 16'd0;
            end
            if ((r_state == ST_LOAD) && bus.in_valid) begin
                r_open[r_cnt] <= bus.maze;
                r_cnt         <= r_cnt + 8'd1;
            end
            if (r_state == ST_WAIT) begin
                r_timer <= r_timer + 16'd1;
            end
            if (w_take_pt) begin
                if (!w_oob) begin
                    r_visited[w_idx] <= 1'b1;
                end
                r_len    <= (r_len == 8'hFF) ? r_len : (r_len + 8'd1);
                r_prev_x <= bus.out_x;
                r_prev_y <= bus.out_y;
            end
            if (w_state_nxt == ST_REPORT) begin
                r_done       <= 1'b1;
                r_pass       <= (w_err_nxt == ERR_NONE);
                r_out_err    <= w_err_nxt;
                r_out_nopath <= w_nopath_nxt;
                r_out_len    <= r_len;
            end else begin
                r_done <= 1'b0;
            end
        end
    end

    assign bus.chk_done   = r_done;
    assign bus.chk_pass   = r_pass;
    assign bus.chk_nopath = r_out_nopath;
    assign bus.chk_err    = r_out_err;
    assign bus.chk_len    = r_out_len;
endmodule

// File: tb/tb_maze_path_checker.sv
// Directed bench: a table of maze/response scenarios with hand-computed verdicts,
// plus hand-written sequences for short load and mid-burst reset.
module tb_maze_path_checker;
    logic clk;
    logic rst;
    maze_path_checker_if bus();

    maze_path_checker dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int M_CORR = 0, M_OPEN = 1, M_OPEN_SW = 2;
    localparam int P_LEGAL = 0, P_JUMP = 1, P_WALL = 2, P_START = 3, P_SHORT = 4,
                   P_SINGLE = 5, P_REVISIT = 6, P_OOB = 7, P_PROTO = 8, P_SAT = 9, P_NONE = 10;
    localparam int R_PATH = 0, R_NOPATH = 1, R_TIMEOUT = 2;

    typedef struct {
        int         maze_kind;
        int         path_kind;
        int         resp;
        logic       exp_pass;
        logic [2:0] exp_err;
        logic       exp_nopath;
        logic [7:0] exp_len;
    } vec_t;

    vec_t vecs[13];
    int   n_cmp;
    int   n_fail;
    int   px[$];
    int   py[$];
    int   proto_idx;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [224:0] maze_bits(input int kind);
        logic [224:0] m;
        m = '1;
        if (kind == M_CORR) begin
            m = '0;
            for (int y = 0; y < 15; y++)
                for (int x = 0; x < 15; x++)
                    if ((x == 1 && y >= 1 && y <= 13) || (y == 13 && x >= 1 && x <= 13))
                        m[y*15+x] = 1'b1;
        end else if (kind == M_OPEN_SW) begin
            m[16] = 1'b0;
        end
        return m;
    endfunction

    task automatic build_path(input int kind);
        px.delete();
        py.delete();
        proto_idx = -1;
        if (kind == P_LEGAL || kind == P_JUMP || kind == P_START || kind == P_SHORT || kind == P_PROTO) begin
            for (int y = 1; y <= 13; y++) begin
                if (!(kind == P_JUMP && y == 6) && !(kind == P_START && y == 1)) begin
                    px.push_back(1); py.push_back(y);
                end
            end
            for (int x = 2; x <= 13; x++) begin
                if (!(kind == P_SHORT && x == 13)) begin
                    px.push_back(x); py.push_back(13);
                end
            end
            if (kind == P_PROTO) proto_idx = 2;
        end else if (kind == P_SINGLE) begin
            px.push_back(1); py.push_back(1);
        end else if (kind == P_REVISIT) begin
            px = '{1, 1, 1}; py = '{1, 2, 1};
        end else if (kind == P_WALL) begin
            px = '{1, 1, 2, 2, 1}; py = '{1, 2, 2, 1, 1};
        end else if (kind == P_OOB) begin
            px = '{1, 15}; py = '{1, 1};
        end else if (kind == P_SAT) begin
            for (int i = 0; i < 260; i++) begin
                px.push_back(1); py.push_back(1 + (i % 2));
            end
        end
    endtask

    task automatic load_maze(input logic [224:0] m);
        for (int i = 0; i < 225; i++) begin
            bus.in_valid = 1'b1;
            bus.maze     = m[i];
            tick();
        end
        bus.in_valid = 1'b0;
        bus.maze     = 1'b0;
    endtask

    task automatic send_path(input string tag);
        int early;
        early = 0;
        for (int i = 0; i < px.size(); i++) begin
            bus.out_valid      = 1'b1;
            bus.out_x          = 4'(px[i]);
            bus.out_y          = 4'(py[i]);
            bus.maze_not_valid = (i == proto_idx);
            tick();
            if (bus.chk_done) early++;
        end
        bus.out_valid      = 1'b0;
        bus.maze_not_valid = 1'b0;
        chk({tag, "_no_early_done"}, early, 0);
    endtask

    task automatic check_verdict(input string tag, input vec_t v);
        chk({tag, "_pass"}, 32'(bus.chk_pass), 32'(v.exp_pass));
        chk({tag, "_err"}, 32'(bus.chk_err), 32'(v.exp_err));
        chk({tag, "_nopath"}, 32'(bus.chk_nopath), 32'(v.exp_nopath));
        chk({tag, "_len"}, 32'(bus.chk_len), 32'(v.exp_len));
    endtask

    task automatic run_vec(input int k, input vec_t v);
        string tag;
        int    waited;
        tag = $sformatf("v%0d", k);
        load_maze(maze_bits(v.maze_kind));
        if (v.resp == R_PATH) begin
            build_path(v.path_kind);
            send_path(tag);
            tick();
            chk({tag, "_done_latency"}, 32'(bus.chk_done), 32'd1);
        end else if (v.resp == R_NOPATH) begin
            bus.maze_not_valid = 1'b1;
            tick();
            bus.maze_not_valid = 1'b0;
            chk({tag, "_done_latency"}, 32'(bus.chk_done), 32'd1);
        end else begin
            waited = 0;
            while (!bus.chk_done && waited < 1100) begin
                tick();
                waited++;
            end
            chk({tag, "_timeout_done"}, 32'(bus.chk_done), 32'd1);
            chk({tag, "_timeout_window"}, 32'(waited >= 1000 && waited <= 1002), 32'd1);
        end
        check_verdict(tag, v);
        tick();
        chk({tag, "_done_one_cycle"}, 32'(bus.chk_done), 32'd0);
    endtask

    initial begin
        vec_t v;
        int   stale;
        n_cmp  = 0;
        n_fail = 0;
        vecs[0]  = '{M_CORR,    P_LEGAL,   R_PATH,    1'b1, 3'd0, 1'b0, 8'd25};
        vecs[1]  = '{M_CORR,    P_JUMP,    R_PATH,    1'b0, 3'd3, 1'b0, 8'd24};
        vecs[2]  = '{M_CORR,    P_WALL,    R_PATH,    1'b0, 3'd2, 1'b0, 8'd5};
        vecs[3]  = '{M_CORR,    P_START,   R_PATH,    1'b0, 3'd1, 1'b0, 8'd24};
        vecs[4]  = '{M_CORR,    P_SHORT,   R_PATH,    1'b0, 3'd5, 1'b0, 8'd24};
        vecs[5]  = '{M_CORR,    P_SINGLE,  R_PATH,    1'b0, 3'd5, 1'b0, 8'd1};
        vecs[6]  = '{M_CORR,    P_REVISIT, R_PATH,    1'b0, 3'd4, 1'b0, 8'd3};
        vecs[7]  = '{M_OPEN,    P_OOB,     R_PATH,    1'b0, 3'd2, 1'b0, 8'd2};
        vecs[8]  = '{M_CORR,    P_PROTO,   R_PATH,    1'b0, 3'd7, 1'b0, 8'd25};
        vecs[9]  = '{M_OPEN,    P_SAT,     R_PATH,    1'b0, 3'd4, 1'b0, 8'd255};
        vecs[10] = '{M_OPEN,    P_NONE,    R_NOPATH,  1'b0, 3'd6, 1'b1, 8'd0};
        vecs[11] = '{M_OPEN_SW, P_NONE,    R_NOPATH,  1'b1, 3'd0, 1'b1, 8'd0};
        vecs[12] = '{M_CORR,    P_NONE,    R_TIMEOUT, 1'b0, 3'd7, 1'b0, 8'd0};

        bus.in_valid = 1'b0; bus.maze = 1'b0; bus.out_valid = 1'b0;
        bus.maze_not_valid = 1'b0; bus.out_x = 4'd0; bus.out_y = 4'd0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        v = '{0, 0, 0, 1'b0, 3'd0, 1'b0, 8'd0};
        chk("reset_done", 32'(bus.chk_done), 32'd0);
        check_verdict("reset", v);

        for (int k = 0; k < 13; k++) run_vec(k, vecs[k]);

        // Load aborted after 100 bits.
        for (int i = 0; i < 100; i++) begin
            bus.in_valid = 1'b1; bus.maze = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        chk("short_load_done", 32'(bus.chk_done), 32'd1);
        v = '{0, 0, 0, 1'b0, 3'd7, 1'b0, 8'd0};
        check_verdict("short_load", v);
        tick();

        // Reset in the middle of a burst, then a clean legal run.
        load_maze(maze_bits(M_CORR));
        build_path(P_LEGAL);
        for (int i = 0; i < 10; i++) begin
            bus.out_valid = 1'b1;
            bus.out_x = 4'(px[i]); bus.out_y = 4'(py[i]);
            tick();
        end
        rst = 1'b1;
        tick();
        bus.out_valid = 1'b0;
        tick();
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.chk_done) stale++;
        end
        chk("rst_no_stale_done", stale, 0);
        chk("rst_len_cleared", 32'(bus.chk_len), 32'd0);
        run_vec(99, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
